// File: rtl/ttl_pkg.sv
// ttl_pkg: shared constants and helpers for the TTL counter chain models.
//   STAGE_W  width of one 74x161/74x191-style counter stage
//   top_of() terminal count value for a given (WIDTH, MODULUS) pair;
//            MODULUS = 0 selects the full binary range 2^WIDTH.
package ttl_pkg;

  localparam int unsigned STAGE_W = 4;

  function automatic logic [63:0] top_of(input int unsigned width,
                                         input longint unsigned modulus);
    logic [63:0] t;
    if (modulus == 64'd0) begin
      t = (64'd1 << width) - 64'd1;
    end else begin
      t = modulus - 64'd1;
    end
    return t;
  endfunction

endpackage

// File: rtl/ttl_counter_nibble.sv
// ttl_counter_nibble: one 4-bit synchronous up/down counter stage.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr_n       synchronous clear (active-low, highest priority)
//   load_n      synchronous parallel load of d (active-low)
//   cnt_en      count enable for this stage (already includes cascade carry)
//   up          direction, 1 = up, 0 = down
//   d           parallel load data
//   q           registered stage value
//   tc          terminal value in the current direction (F up, 0 down)
module ttl_counter_nibble
  import ttl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_n,
  input  logic               load_n,
  input  logic               cnt_en,
  input  logic               up,
  input  logic [STAGE_W-1:0] d,
  output logic [STAGE_W-1:0] q,
  output logic               tc
);

  logic [STAGE_W-1:0] q_q;
  logic [STAGE_W-1:0] q_d;

  // Next-state selection: clear, then load, then count, else hold.
  always_comb begin
    q_d = q_q;
    if (!clr_n) begin
      q_d = {STAGE_W{1'b0}};
    end else if (!load_n) begin
      q_d = d;
    end else if (cnt_en) begin
      if (up) begin
        q_d = q_q + 4'd1;
      end else begin
        q_d = q_q - 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Stage register with asynchronous reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {STAGE_W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = up ? (q_q == {STAGE_W{1'b1}}) : (q_q == {STAGE_W{1'b0}});

endmodule

// File: rtl/ttl_counter_chain.sv
// ttl_counter_chain: parametrised synchronous up/down counter built from
// cascaded 4-bit stages, with synchronous clear, parallel load and optional
// modulus wrap.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (q -> 0)
//   clr_n       synchronous clear, active-low
//   load_n      synchronous parallel load of d, active-low
//   enp, ent    count enables; only ent gates rco
//   up          direction, 1 = up, 0 = down
//   d           parallel load data
//   q           counter value (registered)
//   rco         ripple carry/borrow out, combinational
module ttl_counter_chain
  import ttl_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);

  localparam int unsigned     NSTG   = WIDTH / STAGE_W;
  localparam logic [63:0]     TOP_W  = top_of(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] TOP   = TOP_W[WIDTH-1:0];
  localparam bit              MOD_EN = (MODULUS != 64'd0);

  logic [NSTG-1:0]  tc_s;
  logic [NSTG-1:0]  chain_s;
  logic [WIDTH-1:0] q_s;
  logic             cnt_s;
  logic             wrap_clr_s;
  logic             wrap_load_s;
  logic             stg_clr_n_s;
  logic             stg_load_n_s;
  logic [WIDTH-1:0] stg_d_s;

  assign cnt_s = enp & ent;

  // Modulus wrap: an up-count from TOP (or an out-of-range loaded value)
  // becomes a clear; a down-count from zero becomes a load of TOP. Both
  // only apply when neither external clear nor load is active.
  always_comb begin
    wrap_clr_s  = 1'b0;
    wrap_load_s = 1'b0;
    if (MOD_EN && clr_n && load_n && cnt_s) begin
      if (up) begin
        wrap_clr_s = (q_s >= TOP);
      end else begin
        wrap_load_s = (q_s == {WIDTH{1'b0}});
      end
    end else begin
      wrap_clr_s  = 1'b0;
      wrap_load_s = 1'b0;
    end
  end

  assign stg_clr_n_s  = clr_n & ~wrap_clr_s;
  assign stg_load_n_s = load_n & ~wrap_load_s;
  assign stg_d_s      = wrap_load_s ? TOP : d;

  genvar k;
  generate
    for (k = 0; k < NSTG; k++) begin : g_stage
      // A stage steps only when every lower stage sits at its terminal value.
      if (k == 0) begin : g_first
        assign chain_s[k] = cnt_s;
      end else begin : g_upper
        assign chain_s[k] = chain_s[k-1] & tc_s[k-1];
      end

      ttl_counter_nibble u_nibble (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_n  (stg_clr_n_s),
        .load_n (stg_load_n_s),
        .cnt_en (chain_s[k]),
        .up     (up),
        .d      (stg_d_s[k*STAGE_W +: STAGE_W]),
        .q      (q_s[k*STAGE_W +: STAGE_W]),
        .tc     (tc_s[k])
      );
    end
  endgenerate

  assign q = q_s;

  // Full binary range: terminal value is all stages at their terminal value.
  assign rco = MOD_EN ? (ent & (up ? (q_s == TOP) : (q_s == {WIDTH{1'b0}})))
                      : (ent & (&tc_s));

endmodule
